// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit for the EX stage.
//   MULTU/MULT use shift-add, one multiplier bit per cycle, or a single-cycle
//   combinational product when MUL_FAST=1. DIVU/DIV use restoring radix-2
//   division, one quotient bit per cycle. Both run on operand magnitudes,
//   and the sign is fixed up in DONE.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start_i; latches op_i and operand magnitudes
//   CALC   | one iteration per cycle, counter 0..WIDTH-1
//   DONE   | registers the sign-corrected result and raises ready_o;
//          | returns to IDLE once start_i drops
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       request, held high until ready_o
//   annul_i       abort; the unit returns to IDLE on the next edge
//   op_i          00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opdata1_i     multiplicand / dividend
//   opdata2_i     multiplier / divisor
//   result_o      {hi, lo}: product, or {remainder, quotient}
//   ready_o       result_o valid
//   busy_o        iterating (state CALC)
//   dbz_o         divide by zero, valid with ready_o
//   stallreq_o    pipeline stall request
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o,
  output logic               stallreq_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] acc_q;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}

  // Operand magnitudes; sign bits count only for signed ops.
  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               div_zero;
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    sign1     = op_i[0] & opdata1_i[WIDTH-1];
    sign2     = op_i[0] & opdata2_i[WIDTH-1];
    mag1      = sign1 ? -opdata1_i : opdata1_i;
    mag2      = sign2 ? -opdata2_i : opdata2_i;
    div_zero  = op_i[1] & (opdata2_i == '0);
    fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and try to subtract.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd_q};
    if (diff[WIDTH]) begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    // Add the multiplicand when the current multiplier bit is set, then shift right.
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
  end

  // Sign correction applied in DONE.
  logic [WIDTH-1:0]   quo_raw, rem_raw;
  logic [2*WIDTH-1:0] done_val;

  always_comb begin
    quo_raw = acc_q[WIDTH-1:0];
    rem_raw = acc_q[2*WIDTH-1:WIDTH];
    if (dbz_q) begin
      done_val = acc_q;
    end else if (is_div_q) begin
      done_val = {(neg_rem_q ? -rem_raw : rem_raw), (neg_res_q ? -quo_raw : quo_raw)};
    end else begin
      done_val = neg_res_q ? -acc_q : acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (div_zero || (!op_i[1] && MUL_FAST)) state_d = S_DONE;
            else                                    state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
        end
        S_DONE: begin
          if (ready_o && !start_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      dbz_o     <= 1'b0;
    end else if (annul_i) begin
      // result_o keeps its last value on an abort.
      ready_o <= 1'b0;
      dbz_o   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= sign1 ^ sign2;
            neg_rem_q <= sign1;
            dbz_q     <= div_zero;
            cnt_q     <= '0;
            opnd_q    <= op_i[1] ? mag2 : mag1;
            if (div_zero) begin
              // Quotient all ones, remainder is the raw dividend.
              acc_q <= {opdata1_i, {WIDTH{1'b1}}};
            end else if (op_i[1]) begin
              acc_q <= {{WIDTH{1'b0}}, mag1};
            end else if (MUL_FAST) begin
              acc_q <= fast_prod;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, mag2};
            end
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: begin
          if (!ready_o) begin
            result_o <= done_val;
            ready_o  <= 1'b1;
            dbz_o    <= dbz_q;
          end else if (!start_i) begin
            ready_o <= 1'b0;
            dbz_o   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = (state_q == S_CALC);
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic         start_s [2];
  logic         annul_s [2];
  logic [1:0]   op_s    [2];
  logic [W-1:0] a_s     [2];
  logic [W-1:0] b_s     [2];
  logic [2*W-1:0] res_s [2];
  logic ready_s [2];
  logic busy_s  [2];
  logic dbz_s   [2];
  logic stall_s [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(W), .MUL_FAST(1'b0)) dut (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .annul_i(annul_s[0]), .op_i(op_s[0]),
    .opdata1_i(a_s[0]), .opdata2_i(b_s[0]), .result_o(res_s[0]), .ready_o(ready_s[0]),
    .busy_o(busy_s[0]), .dbz_o(dbz_s[0]), .stallreq_o(stall_s[0])
  );

  muldiv_iter #(.WIDTH(W), .MUL_FAST(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .annul_i(annul_s[1]), .op_i(op_s[1]),
    .opdata1_i(a_s[1]), .opdata2_i(b_s[1]), .result_o(res_s[1]), .ready_o(ready_s[1]),
    .busy_o(busy_s[1]), .dbz_o(dbz_s[1]), .stallreq_o(stall_s[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {dbz, result} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return {1'b0, 64'(a) * 64'(b)};
      2'b01: return {1'b0, 64'(sa * sb)};
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic int exp_lat(input int k, input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 0) return 1;
    if (!op[1] && k == 1) return 1;
    return W + 1;
  endfunction

  // Raises start and counts edges (edge 0 = first edge with start high) until ready.
  task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic dbz, output int lat);
    @(negedge clk);
    op_s[k] = op; a_s[k] = a; b_s[k] = b; start_s[k] = 1'b1;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 0) chk("stallreq_waiting", stall_s[k], 1'b1);
      if (ready_s[k]) begin
        lat = n;
        break;
      end
    end
    res = res_s[k];
    dbz = dbz_s[k];
    chk("stallreq_ready", stall_s[k], 1'b0);
  endtask

  task automatic release_op(input int k);
    @(negedge clk);
    start_s[k] = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", ready_s[k], 1'b0);
  endtask

  typedef struct {
    int          k;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r, prev;
    logic        d;
    int          lat;
    logic [64:0] m;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          k;
    bit          rose;

    vt[0] = '{0, 2'b10, 32'd100,        32'd7,          {32'd2, 32'd14},               1'b0, 33};
    vt[1] = '{0, 2'b11, 32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD,       1'b0, 33};
    vt[2] = '{0, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},        1'b0, 33};
    vt[3] = '{0, 2'b01, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1,       1'b0, 33};
    vt[4] = '{1, 2'b01, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1,       1'b0, 1};
    vt[5] = '{0, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,       1'b0, 33};
    vt[6] = '{1, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,       1'b0, 1};
    vt[7] = '{0, 2'b10, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},        1'b1, 1};
    vt[8] = '{0, 2'b11, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},        1'b0, 33};
    vt[9] = '{1, 2'b11, 32'hFFFF_FFF9,  32'd0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, 1};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; annul_s[i] = 1'b0; op_s[i] = 2'b00; a_s[i] = '0; b_s[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_result", res_s[0], 64'd0);
    chk("reset_ready",  ready_s[0], 1'b0);
    chk("reset_busy",   busy_s[0], 1'b0);
    chk("reset_dbz",    dbz_s[0], 1'b0);
    chk("reset_stall",  stall_s[0], 1'b0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].k, vt[i].op, vt[i].a, vt[i].b, r, d, lat);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_dbz", i), d, vt[i].dbz);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      release_op(vt[i].k);
    end

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      k  = i % 2;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      m = model(op, a, b);
      run_op(k, op, a, b, r, d, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, op), r, m[63:0]);
      chk($sformatf("rnd%0d_op%0d_dbz", i, op), d, m[64]);
      chk($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat), 64'(exp_lat(k, op, b)));
      release_op(k);
    end

    // Abort at CALC cycle 10, then a fresh divide
    prev = res_s[0];
    @(negedge clk);
    op_s[0] = 2'b10; a_s[0] = 32'd1000; b_s[0] = 32'd3; start_s[0] = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk("annul_busy_before", busy_s[0], 1'b1);
    @(negedge clk);
    annul_s[0] = 1'b1;
    #1;
    chk("annul_stall_masked", stall_s[0], 1'b0);
    @(posedge clk); #1;
    chk("annul_busy_after", busy_s[0], 1'b0);
    chk("annul_ready_after", ready_s[0], 1'b0);
    chk("annul_result_kept", res_s[0], prev);
    @(posedge clk); #1;
    chk("annul_beats_start", busy_s[0], 1'b0);
    @(negedge clk);
    annul_s[0] = 1'b0; start_s[0] = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_s[0]) rose = 1'b1;
    end
    chk("annul_ready_never", rose, 1'b0);
    run_op(0, 2'b10, 32'd9, 32'd3, r, d, lat);
    chk("after_annul_result", r, {32'd0, 32'd3});
    chk("after_annul_latency", 64'(lat), 64'(W + 1));
    release_op(0);

    // Operand changes after launch are ignored; hold start in DONE
    @(negedge clk);
    op_s[0] = 2'b10; a_s[0] = 32'd100; b_s[0] = 32'd7; start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_s[0] = 2'b01; a_s[0] = 32'hDEAD_BEEF; b_s[0] = 32'd0;
    lat = -1;
    for (int n = 1; n < 100; n++) begin
      @(posedge clk); #1;
      if (ready_s[0]) begin
        lat = n;
        break;
      end
    end
    chk("hold_latency", 64'(lat), 64'(W + 1));
    chk("hold_result", res_s[0], {32'd2, 32'd14});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_ready", i), ready_s[0], 1'b1);
      chk($sformatf("hold%0d_result", i), res_s[0], {32'd2, 32'd14});
    end
    release_op(0);
    chk("hold_idle_busy", busy_s[0], 1'b0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    op_s[0] = 2'b10; a_s[0] = 32'd100; b_s[0] = 32'd7; start_s[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy_s[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset_result", res_s[0], 64'd0);
    chk("async_reset_ready",  ready_s[0], 1'b0);
    chk("async_reset_busy",   busy_s[0], 1'b0);
    chk("async_reset_dbz",    dbz_s[0], 1'b0);
    @(negedge clk);
    start_s[0] = 1'b0;
    rst = 1'b0;
    run_op(0, 2'b11, 32'hFFFF_FFF9, 32'd2, r, d, lat);
    chk("post_reset_result", r, 64'hFFFF_FFFF_FFFF_FFFD);
    release_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
